wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the LEGv8 five-stage pipeline. It holds the MEM/WB pipeline register, waits for variable-latency data-memory load responses, and size/sign-extends load data. It selects the writeback value and drives the write port (`we3`, `wa3`, `wd3`) of the 32×N register file. It also stalls upstream stages while a load is outstanding and counts retired instructions.

## Interface
Parameters:
- `N`, 64, datapath width.
- `CNT_W`, 32, retire counter width.

Ports:
- `clk`  in  1  pipeline clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  MEM stage presents an instruction.
- `mem_regwrite`  in  1  instruction writes a register.
- `mem_memtoreg`  in  1  instruction is a load.
- `mem_ldsize`  in  2  load size: 00 byte, 01 half, 10 word, 11 dword.
- `mem_ldsigned`  in  1  sign-extend the load (LDURSW style).
- `mem_wa`  in  5  destination register.
- `mem_alu`  in  N  ALU result, or the link value for BL.
- `dm_rvalid`  in  1  data-memory read data valid.
- `dm_rdata`  in  N  data-memory read data, right-aligned.
- `stall`  out  1  freeze the IF..MEM pipeline registers.
- `we3`  out  1  register-file write enable.
- `wa3`  out  5  register-file write address.
- `wd3`  out  N  register-file write data.
- `retired`  out  CNT_W  count of completed instructions.
- `dm_err`  out  1  sticky flag: unexpected `dm_rvalid`.

## Operation
- States:
  - IDLE: no instruction.
  - EXEC: non-load, completes this cycle.
  - WAIT: load, data pending.
  - LDWB: load data captured, completes this cycle.
- Capture occurs at posedge when `stall`=0. The pipeline register loads all `mem_*` fields. Next state:
  - `mem_valid`=0 → IDLE.
  - `mem_valid`=1, `mem_memtoreg`=0 → EXEC.
  - `mem_valid`=1, `mem_memtoreg`=1 → WAIT.
- In WAIT:
  - `stall`=1. The pipeline register holds and `mem_*` is ignored.
  - `dm_rvalid`=1 captures the extended `dm_rdata` into a data register and moves to LDWB.
  - Otherwise the block remains in WAIT, with no timeout.
- `dm_rvalid` is sampled only in WAIT. When it is high in any other state, `dm_err` is set until reset and the data is discarded.
- Write enable: `we3` = (state is EXEC or LDWB) & regwrite & (wa ≠ 31). Writes to XZR are suppressed.
- `wa3` = registered wa. `wd3` = data register in LDWB, otherwise registered alu.
- Load extension (low bits of `dm_rdata`):
  - Byte: bits [7:0].
  - Half: bits [15:0].
  - Word: bits [31:0].
  - Upper bits are filled with the MSB of the field when `ldsigned`=1, otherwise with zero.
  - Dword passes through unchanged and ignores `ldsigned`.
- `retired` increments by 1 in every EXEC or LDWB cycle, regardless of regwrite (stores and branches count). It wraps modulo 2^CNT_W.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - state=IDLE.
  - `stall`=0, `we3`=0, `wa3`=0, `wd3`=0.
  - `retired`=0, `dm_err`=0.
  - Pipeline and data registers are cleared.
- Reset asserted during WAIT abandons the load: no write occurs, and a later `dm_rvalid` raises `dm_err`.
- All outputs decode from registers only. There is no combinational path from `mem_*` or `dm_*` to any output.
- Non-load: captured at edge k, `we3` high during cycle k, register-file write at edge k+1. Latency is 1 cycle.
- Load: captured at edge k. If `dm_rvalid` is first high in cycle k+j (j≥0), then LDWB occurs in cycle k+j+1 and the write happens at edge k+j+2. `stall` is high in cycles k..k+j.
- LDWB and EXEC both accept a new instruction at their closing edge. Back-to-back loads give one WAIT cycle minimum per load.
- `stall` depends only on state. Upstream sees it in the same cycle it is asserted.

## Structure
- `wb_pkg` holds:
  - the `wb_state_t` enum (IDLE, EXEC, WAIT, LDWB);
  - the `ldsize_t` codes;
  - the constant `XZR` = 5'd31.
- Sub-module `load_extend`: combinational extension of (`ldsize`, `ldsigned`, `dm_rdata`) → N-bit value. It is instantiated once and feeds the data register.
- Top level: state machine, pipeline register, data register, retire counter, `dm_err` flag.

## Test plan
- ALU op with wa=5, alu=64'h1234 → `we3`=1, `wa3`=5, `wd3`=64'h1234 one cycle after capture; `retired`=1.
- Write to XZR: wa=31, regwrite=1 → `we3`=0 and `retired` increments.
- LDURB signed, `dm_rdata`=64'h…80 arriving after 3 WAIT cycles → `stall`=1 for 3 cycles, then `wd3`=64'hFFFF_FFFF_FFFF_FF80; unsigned gives 64'h80.
- Back-to-back loads, each with `dm_rvalid` in the first WAIT cycle → WAIT, LDWB, WAIT, LDWB; two writes; `retired`=2.
- `dm_rvalid` pulse in IDLE → `dm_err`=1 and stays set; no write occurs.
- `reset_n` low during WAIT → all outputs reach their reset values immediately; a later `dm_rvalid` produces no write and sets `dm_err`.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the LEGv8 writeback stage
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WAIT = 2'd2,
    LDWB = 2'd3
  } wb_state_t;

  typedef enum logic [1:0] {
    LD_BYTE  = 2'b00,
    LD_HALF  = 2'b01,
    LD_WORD  = 2'b10,
    LD_DWORD = 2'b11
  } ldsize_t;

  localparam logic [4:0] XZR = 5'd31;

  // Control half of the MEM/WB register; the N-bit ALU value is kept separately.
  typedef struct packed {
    logic       regwrite;
    ldsize_t    ldsize;
    logic       ldsigned;
    logic [4:0] wa;
  } wb_ctrl_t;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - size/sign extension of right-aligned load data
module load_extend
  import wb_pkg::*;
#(
  parameter int N = 64
) (
  input  ldsize_t        ldsize,
  input  logic           ldsigned,
  input  logic [N-1:0]   rdata,
  output logic [N-1:0]   ext
);

  always_comb begin
    ext = rdata;
    case (ldsize)
      LD_BYTE:  ext = {{(N-8){ldsigned & rdata[7]}}, rdata[7:0]};
      LD_HALF:  ext = {{(N-16){ldsigned & rdata[15]}}, rdata[15:0]};
      LD_WORD:  ext = {{(N-32){ldsigned & rdata[31]}}, rdata[31:0]};
      LD_DWORD: ext = rdata;
      default:  ext = rdata;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB register, load-response wait, register-file write port
module wb_stage
  import wb_pkg::*;
#(
  parameter int N     = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_valid,
  input  logic             mem_regwrite,
  input  logic             mem_memtoreg,
  input  logic [1:0]       mem_ldsize,
  input  logic             mem_ldsigned,
  input  logic [4:0]       mem_wa,
  input  logic [N-1:0]     mem_alu,
  input  logic             dm_rvalid,
  input  logic [N-1:0]     dm_rdata,
  output logic             stall,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [N-1:0]     wd3,
  output logic [CNT_W-1:0] retired,
  output logic             dm_err
);

  wb_state_t      state_q, state_d;
  wb_ctrl_t       ctrl_q;
  logic [N-1:0]   alu_q;
  logic [N-1:0]   data_q;
  logic [N-1:0]   ext_data;
  logic [CNT_W-1:0] retired_q;
  logic           err_q;
  logic           capture;
  logic           completing;

  // The pipeline register is frozen for the whole time a load is outstanding.
  assign capture    = (state_q != WAIT);
  assign completing = (state_q == EXEC) || (state_q == LDWB);

  load_extend #(.N(N)) u_load_extend (
    .ldsize   (ctrl_q.ldsize),
    .ldsigned (ctrl_q.ldsigned),
    .rdata    (dm_rdata),
    .ext      (ext_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT: begin
        if (dm_rvalid) state_d = LDWB;
      end
      default: begin
        if (!mem_valid)       state_d = IDLE;
        else if (mem_memtoreg) state_d = WAIT;
        else                   state_d = EXEC;
      end
    endcase
  end

  always_comb begin
    stall = (state_q == WAIT);
    we3   = completing && ctrl_q.regwrite && (ctrl_q.wa != XZR);
    wa3   = ctrl_q.wa;
    wd3   = (state_q == LDWB) ? data_q : alu_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
      alu_q  <= '0;
      data_q <= '0;
    end else begin
      if (capture) begin
        ctrl_q.regwrite <= mem_regwrite;
        ctrl_q.ldsize   <= ldsize_t'(mem_ldsize);
        ctrl_q.ldsigned <= mem_ldsigned;
        ctrl_q.wa       <= mem_wa;
        alu_q           <= mem_alu;
      end
      if ((state_q == WAIT) && dm_rvalid) begin
        data_q <= ext_data;
      end
    end
  end

  // Read data arriving while no load is outstanding is dropped and flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (completing) retired_q <= retired_q + CNT_W'(1);
      if (dm_rvalid && (state_q != WAIT)) err_q <= 1'b1;
    end
  end

  assign retired = retired_q;
  assign dm_err  = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - self-checking bench for wb_stage
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_valid, mem_regwrite, mem_memtoreg, mem_ldsigned;
  logic [1:0]  mem_ldsize;
  logic [4:0]  mem_wa;
  logic [63:0] mem_alu;
  logic        dm_rvalid;
  logic [63:0] dm_rdata;
  logic        stall, we3, dm_err;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_stage #(.N(64), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg),
    .mem_ldsize(mem_ldsize), .mem_ldsigned(mem_ldsigned), .mem_wa(mem_wa), .mem_alu(mem_alu),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .stall(stall), .we3(we3), .wa3(wa3), .wd3(wd3), .retired(retired), .dm_err(dm_err)
  );

  typedef struct {
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] rdata;
    logic [63:0] exp;
  } ld_vec_t;

  ld_vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_valid = 0; mem_regwrite = 0; mem_memtoreg = 0; mem_ldsize = 0;
    mem_ldsigned = 0; mem_wa = 0; mem_alu = 0; dm_rvalid = 0; dm_rdata = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [1:0] size,
                       input logic sgn, input logic [4:0] wa, input logic [63:0] alu);
    mem_valid = 1; mem_regwrite = rw; mem_memtoreg = m2r; mem_ldsize = size;
    mem_ldsigned = sgn; mem_wa = wa; mem_alu = alu;
  endtask

  // Issues a load, lets it sit nwait (>=1) WAIT cycles, returns at the negedge of LDWB.
  task automatic do_load(input logic [1:0] size, input logic sgn, input logic [4:0] wa,
                         input logic [63:0] rdata, input int nwait,
                         output int scnt, output logic got_we, output logic [63:0] got_wd);
    drive(1, 1, size, sgn, wa, {$urandom, $urandom});
    dm_rvalid = 0;
    scnt = 0;
    for (int i = 0; i < nwait; i++) begin
      @(negedge clk);
      mem_valid = 0;
      if (stall) scnt++;
      if (i == nwait - 1) begin
        dm_rvalid = 1;
        dm_rdata  = rdata;
      end
    end
    @(negedge clk);
    dm_rvalid = 0;
    if (stall) scnt++;
    got_we = we3;
    got_wd = wd3;
  endtask

  function automatic logic [63:0] ref_ext(input logic [63:0] d, input logic [1:0] size, input logic sgn);
    int w;
    logic [63:0] mask, v;
    if (size == 2'b11) return d;
    w    = 8 << size;
    mask = (64'd1 << w) - 64'd1;
    v    = d & mask;
    if (sgn && d[w-1]) v = v | ~mask;
    return v;
  endfunction

  // Reference model: one instruction slot that is either waiting for load data or completing.
  logic        m_waiting, m_done, m_isload, m_rw, m_sgn, m_err;
  logic [1:0]  m_size;
  logic [4:0]  m_wa;
  logic [63:0] m_alu, m_data;
  int unsigned m_ret;

  initial begin
    int scnt;
    logic gwe;
    logic [63:0] gwd;

    vecs[0] = '{2'b00, 1'b1, 64'h0123_4567_89AB_CD80, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{2'b00, 1'b0, 64'h0123_4567_89AB_CD80, 64'h0000_0000_0000_0080};
    vecs[2] = '{2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FF7F, 64'h0000_0000_0000_007F};
    vecs[3] = '{2'b01, 1'b1, 64'hAAAA_BBBB_CCCC_8001, 64'hFFFF_FFFF_FFFF_8001};
    vecs[4] = '{2'b01, 1'b0, 64'hAAAA_BBBB_CCCC_8001, 64'h0000_0000_0000_8001};
    vecs[5] = '{2'b10, 1'b1, 64'h1111_2222_8000_0000, 64'hFFFF_FFFF_8000_0000};
    vecs[6] = '{2'b10, 1'b0, 64'h1111_2222_8000_0000, 64'h0000_0000_8000_0000};
    vecs[7] = '{2'b10, 1'b1, 64'hFFFF_FFFF_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF};
    vecs[8] = '{2'b11, 1'b1, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001};
    vecs[9] = '{2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};

    // Reset state
    do_reset();
    chk("reset_stall", stall, 0);
    chk("reset_we3", we3, 0);
    chk("reset_wa3", wa3, 0);
    chk("reset_wd3", wd3, 0);
    chk("reset_retired", retired, 0);
    chk("reset_dm_err", dm_err, 0);

    // ALU op
    drive(1, 0, 0, 0, 5'd5, 64'h1234);
    @(negedge clk);
    idle_inputs();
    chk("alu_we3", we3, 1);
    chk("alu_wa3", wa3, 5);
    chk("alu_wd3", wd3, 64'h1234);
    chk("alu_stall", stall, 0);
    @(negedge clk);
    chk("alu_retired", retired, 1);
    chk("alu_we3_after", we3, 0);

    // Write to XZR
    drive(1, 0, 0, 0, 5'd31, 64'h55);
    @(negedge clk);
    idle_inputs();
    chk("xzr_we3", we3, 0);
    @(negedge clk);
    chk("xzr_retired", retired, 2);

    // Signed byte load, data after 3 WAIT cycles
    do_load(2'b00, 1, 5'd7, 64'h0000_0000_0000_0080, 3, scnt, gwe, gwd);
    chk("ldb_stall_cycles", scnt, 3);
    chk("ldb_we3", gwe, 1);
    chk("ldb_wa3", wa3, 7);
    chk("ldb_wd3_signed", gwd, 64'hFFFF_FFFF_FFFF_FF80);
    @(negedge clk);
    chk("ldb_retired", retired, 3);
    do_load(2'b00, 0, 5'd7, 64'h0000_0000_0000_0080, 3, scnt, gwe, gwd);
    chk("ldb_wd3_unsigned", gwd, 64'h80);
    @(negedge clk);

    // Extension table
    foreach (vecs[i]) begin
      do_load(vecs[i].size, vecs[i].sgn, 5'(i + 1), vecs[i].rdata, 1 + (i % 2), scnt, gwe, gwd);
      chk($sformatf("ext_vec%0d_wd3", i), gwd, vecs[i].exp);
      chk($sformatf("ext_vec%0d_stall", i), scnt, 1 + (i % 2));
      @(negedge clk);
    end

    // Back-to-back loads, data in first WAIT cycle
    do_reset();
    drive(1, 1, 2'b11, 0, 5'd3, 64'h0);
    @(negedge clk);
    chk("b2b_a_stall", stall, 1);
    mem_valid = 0; dm_rvalid = 1; dm_rdata = 64'hA;
    @(negedge clk);
    chk("b2b_a_we3", we3, 1);
    chk("b2b_a_wd3", wd3, 64'hA);
    chk("b2b_a_ldwb_stall", stall, 0);
    dm_rvalid = 0;
    drive(1, 1, 2'b11, 0, 5'd4, 64'h0);
    @(negedge clk);
    chk("b2b_b_stall", stall, 1);
    chk("b2b_b_we3_wait", we3, 0);
    mem_valid = 0; dm_rvalid = 1; dm_rdata = 64'hB;
    @(negedge clk);
    chk("b2b_b_we3", we3, 1);
    chk("b2b_b_wa3", wa3, 4);
    chk("b2b_b_wd3", wd3, 64'hB);
    dm_rvalid = 0;
    @(negedge clk);
    chk("b2b_retired", retired, 2);
    chk("b2b_no_err", dm_err, 0);

    // dm_rvalid in IDLE
    do_reset();
    dm_rvalid = 1; dm_rdata = 64'hFF;
    @(negedge clk);
    dm_rvalid = 0;
    chk("idle_rvalid_err", dm_err, 1);
    chk("idle_rvalid_we3", we3, 0);
    chk("idle_rvalid_state", stall, 0);
    repeat (3) @(negedge clk);
    chk("idle_rvalid_sticky", dm_err, 1);
    chk("idle_rvalid_retired", retired, 0);

    // Reset during WAIT
    do_reset();
    drive(1, 1, 2'b11, 0, 5'd9, 64'h77);
    @(negedge clk);
    mem_valid = 0;
    chk("rstwait_stall", stall, 1);
    #2 reset_n = 0;
    #1;
    chk("rstwait_stall0", stall, 0);
    chk("rstwait_we3", we3, 0);
    chk("rstwait_wa3", wa3, 0);
    chk("rstwait_wd3", wd3, 0);
    chk("rstwait_err0", dm_err, 0);
    @(negedge clk);
    reset_n = 1;
    dm_rvalid = 1; dm_rdata = 64'h1;
    @(negedge clk);
    dm_rvalid = 0;
    chk("rstwait_late_err", dm_err, 1);
    chk("rstwait_late_we3", we3, 0);
    @(negedge clk);
    chk("rstwait_late_retired", retired, 0);

    // Randomized run against the reference model
    do_reset();
    m_waiting = 0; m_done = 0; m_isload = 0; m_rw = 0; m_sgn = 0; m_err = 0;
    m_size = 0; m_wa = 0; m_alu = 0; m_data = 0; m_ret = 0;
    for (int c = 0; c < 3000; c++) begin
      logic exp_we;
      @(negedge clk);
      exp_we = m_done && m_rw && (m_wa != 5'd31);
      chk("rnd_stall", stall, m_waiting);
      chk("rnd_we3", we3, exp_we);
      if (exp_we) begin
        chk("rnd_wa3", wa3, m_wa);
        chk("rnd_wd3", wd3, m_isload ? m_data : m_alu);
      end
      chk("rnd_retired", retired, m_ret);
      chk("rnd_dm_err", dm_err, m_err);

      mem_valid    = ($urandom_range(0, 9) < 8);
      mem_regwrite = $urandom_range(0, 3) != 0;
      mem_memtoreg = $urandom_range(0, 1);
      mem_ldsize   = 2'($urandom_range(0, 3));
      mem_ldsigned = $urandom_range(0, 1);
      mem_wa       = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom);
      mem_alu      = {$urandom, $urandom};
      dm_rdata     = {$urandom, $urandom};
      dm_rvalid    = m_waiting ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 199) == 0);

      if (m_done) m_ret++;
      if (dm_rvalid && !m_waiting) m_err = 1;
      if (m_waiting) begin
        if (dm_rvalid) begin
          m_data = ref_ext(dm_rdata, m_size, m_sgn);
          m_waiting = 0;
          m_done = 1;
        end
      end else begin
        m_rw = mem_regwrite; m_wa = mem_wa; m_alu = mem_alu;
        m_size = mem_ldsize; m_sgn = mem_ldsigned;
        m_isload = mem_memtoreg;
        m_done = mem_valid && !mem_memtoreg;
        m_waiting = mem_valid && mem_memtoreg;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
